// File: rtl/pwm_deadtime.sv
// Complementary high/low-side drive generator with per-channel dead time and a
// global latched fault that forces every channel inactive until cleared.
module pwm_deadtime #(
    parameter int NOutputs = 6,
    parameter int DtCntDw  = 8
) (
    input  logic                        clk_core_i,
    input  logic                        rst_core_i,
    input  logic [NOutputs-1:0]         pwm_i,
    input  logic [NOutputs-1:0]         dt_en_i,
    input  logic [NOutputs*DtCntDw-1:0] dt_rise_i,
    input  logic [NOutputs*DtCntDw-1:0] dt_fall_i,
    input  logic                        fault_i,
    input  logic                        fault_clr_i,
    output logic [NOutputs-1:0]         pwm_hi_o,
    output logic [NOutputs-1:0]         pwm_lo_o,
    output logic                        fault_o
);

    typedef enum logic [1:0] {
        S_LO   = 2'd0,
        S_DT_R = 2'd1,
        S_HI   = 2'd2,
        S_DT_F = 2'd3
    } state_e;

    localparam logic [DtCntDw-1:0] CntOne = {{(DtCntDw-1){1'b0}}, 1'b1};

    logic fault_reg;

    // Set has priority over clear so a persisting fault cannot be cleared away.
    always_ff @(posedge clk_core_i) begin
        if (rst_core_i) begin
            fault_reg <= 1'b0;
        end else if (fault_i) begin
            fault_reg <= 1'b1;
        end else if (fault_clr_i) begin
            fault_reg <= 1'b0;
        end
    end

    assign fault_o = fault_reg;

    generate
        for (genvar gi = 0; gi < NOutputs; gi++) begin : g_ch
            state_e             state_reg, state_next;
            logic [DtCntDw-1:0] cnt_reg, cnt_next;
            logic [DtCntDw-1:0] dt_rise, dt_fall;

            assign dt_rise = dt_rise_i[gi*DtCntDw +: DtCntDw];
            assign dt_fall = dt_fall_i[gi*DtCntDw +: DtCntDw];

            always_ff @(posedge clk_core_i) begin
                if (rst_core_i) begin
                    state_reg <= S_DT_F;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                if (fault_reg) begin
                    // Park in falling dead time so release always waits dt_fall.
                    state_next = S_DT_F;
                    cnt_next   = dt_fall;
                end else if (!dt_en_i[gi]) begin
                    state_next = pwm_i[gi] ? S_HI : S_LO;
                end else begin
                    case (state_reg)
                        S_LO: begin
                            if (pwm_i[gi]) begin
                                if (dt_rise == '0) begin
                                    state_next = S_HI;
                                end else begin
                                    state_next = S_DT_R;
                                    cnt_next   = dt_rise;
                                end
                            end
                        end
                        S_DT_R: begin
                            if (!pwm_i[gi]) begin
                                state_next = S_LO;
                            end else if (cnt_reg <= CntOne) begin
                                state_next = S_HI;
                            end else begin
                                cnt_next = cnt_reg - CntOne;
                            end
                        end
                        S_HI: begin
                            if (!pwm_i[gi]) begin
                                if (dt_fall == '0) begin
                                    state_next = S_LO;
                                end else begin
                                    state_next = S_DT_F;
                                    cnt_next   = dt_fall;
                                end
                            end
                        end
                        S_DT_F: begin
                            if (pwm_i[gi]) begin
                                state_next = S_HI;
                            end else if (cnt_reg <= CntOne) begin
                                state_next = S_LO;
                            end else begin
                                cnt_next = cnt_reg - CntOne;
                            end
                        end
                        default: begin
                            state_next = S_DT_F;
                            cnt_next   = dt_fall;
                        end
                    endcase
                end
            end

            assign pwm_hi_o[gi] = (state_reg == S_HI) && !fault_reg;
            assign pwm_lo_o[gi] = (state_reg == S_LO) && !fault_reg;
        end
    endgenerate

endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
Downstream output stage of the PWM core. Takes each channel's single-ended PWM waveform (same clock domain) and produces a complementary high-side/low-side pair with programmable per-channel dead time. Both sides are never active simultaneously. A latched fault input forces all outputs inactive until software clears it. It sits between the PWM core's per-channel outputs and the pad/driver logic.

Parameters:
NOutputs, 6, number of channels; must match the PWM core channel count.
DtCntDw, 8, dead-time counter width; max dead time is 2^DtCntDw-1 core cycles.

Ports:
clk_core_i  input  1  core clock; all logic on posedge.
rst_core_i  input  1  reset, synchronous, active-high.
pwm_i  input  NOutputs  per-channel PWM waveform from the PWM core, synchronous to clk_core_i.
dt_en_i  input  NOutputs  per-channel dead-time enable; 0 selects bypass.
dt_rise_i  input  NOutputs*DtCntDw  per-channel dead time before hi turns on; channel ii uses slice [ii*DtCntDw +: DtCntDw].
dt_fall_i  input  NOutputs*DtCntDw  per-channel dead time before lo turns on; same slicing.
fault_i  input  1  fault request; level, synchronous.
fault_clr_i  input  1  single-cycle fault-clear pulse.
pwm_hi_o  output  NOutputs  high-side drive, active-high.
pwm_lo_o  output  NOutputs  low-side drive, active-high.
fault_o  output  1  latched fault status.

Behaviour:
- Per-channel Moore FSM: state register plus down-counter cnt[DtCntDw-1:0]. Outputs decode from registered state only; no combinational path from pwm_i to outputs.
- States and outputs:
  - S_LO: lo=1, hi=0.
  - S_DT_R: both 0; counting toward HI.
  - S_HI: hi=1, lo=0.
  - S_DT_F: both 0; counting toward LO.
- Reset: state=S_DT_F, cnt=0, fault_q=0. During reset and in the first cycle after it, pwm_hi_o=0, pwm_lo_o=0, fault_o=0.
- Transitions when dt_en_i[ii]=1 and fault_q=0:
  - S_LO: pwm_i=1 and dt_rise=0 -> S_HI. pwm_i=1 and dt_rise>0 -> S_DT_R, cnt<=dt_rise. Otherwise stay.
  - S_DT_R: pwm_i=0 -> S_LO (abort; hi never asserted). Else cnt<=1 -> S_HI. Else cnt<=cnt-1.
  - S_HI: pwm_i=0 and dt_fall=0 -> S_LO. pwm_i=0 and dt_fall>0 -> S_DT_F, cnt<=dt_fall. Otherwise stay.
  - S_DT_F: pwm_i=1 -> S_HI (abort; lo never asserted). Else cnt<=1 -> S_LO. Else cnt<=cnt-1.
- Resulting timing:
  - A rising edge on pwm_i (pwm_i=1 first sampled at edge N) gives lo=0 from cycle N+1, and hi=1 from cycle N+1+dt_rise.
  - A falling edge gives lo=1 from cycle N+1+dt_fall.
  - With dt=0, latency is 1 cycle.
- Pulse swallowing: a high pulse of width w <= dt_rise never asserts hi; lo is deasserted for w cycles. Symmetric for low pulses versus dt_fall.
- dt_rise_i/dt_fall_i are sampled only when loading cnt. Changes while counting take effect at the next transition.
- Bypass (dt_en_i[ii]=0, fault_q=0): next state = pwm_i ? S_HI : S_LO, so hi=pwm_i and lo=~pwm_i delayed 1 cycle. Toggling dt_en_i mid-count: bypass overrides immediately (next state per bypass rule).
- Fault:
  - fault_q <= 1 when fault_i=1.
  - fault_q <= 0 when fault_clr_i=1 and fault_i=0.
  - Set wins over clear in the same cycle. fault_o = fault_q.
  - While fault_q=1, every channel is forced to S_DT_F with cnt<=dt_fall (full dead time on release), and both outputs are additionally gated to 0 by fault_q.
  - Both outputs are 0 starting one cycle after fault_i is first sampled high.
  - After clear, the FSM resumes from S_DT_F under the normal rules.
- Invariant: pwm_hi_o[ii] & pwm_lo_o[ii] == 0 in every cycle, including reset, bypass switching and fault entry/exit.
- Channels are fully independent; fault is global.

Test Plan:
- Reset then pwm_i=0, dt_en=1, dt_rise=dt_fall=3 -> hi=lo=0 for 1 cycle after reset deassert, then lo=1; hi stays 0.
- Rising edge on pwm_i at cycle N with dt_rise=3 -> lo=0 at N+1, hi=1 at N+4. Falling edge at M with dt_fall=2 -> hi=0 at M+1, lo=1 at M+3.
- 2-cycle high pulse with dt_rise=3 -> hi never asserts; lo low for exactly 2 cycles; no overlap.
- dt_en=0, pwm_i toggling every cycle -> hi=pwm_i and lo=~pwm_i delayed 1 cycle. dt_rise=dt_fall=0 with dt_en=1 gives identical output.
- fault_i pulse while ch0 is HI -> next cycle all outputs 0 and fault_o=1. fault_clr_i asserted with fault_i=1 -> fault stays set. Later clear with fault_i=0 and pwm_i=0 -> lo=1 after dt_fall+1 cycles.
- Random pwm_i/dt values on all NOutputs over 10k cycles -> assertion hi&lo==0 holds every cycle; per-channel outputs independent.
